voice_phase_scheduler: RTL



---
 rtl/synth_pkg.sv | 34 +++
 rtl/voice_phase_scheduler_if.sv | 41 ++++
 rtl/voice_phase_scheduler_voice_alloc.sv | 70 +++++++
 rtl/voice_phase_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : synth_pkg
//  Purpose  : Shared widths, FSM state encoding, allocator action codes and
//             the per-voice record for the voice phase scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int PHASE_W = 32;
    localparam int NOTE_W  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_RETRIG = 3'd1,
        ACT_FREE   = 3'd2,
        ACT_STEAL  = 3'd3,
        ACT_OFF    = 3'd4
    } alloc_act_t;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic [PHASE_W-1:0] phase;
        logic               gate;
    } voice_t;

endpackage
`default_nettype wire

// File: rtl/voice_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : voice_phase_scheduler_if
//  Purpose  : Bundles the note-event handshake, lookup-table port and phase
//             output stream of the voice phase scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface voice_phase_scheduler_if
    import synth_pkg::*;
#(
    parameter int VOICE_W = 3
);
    logic               sample_tick;
    logic               note_valid;
    logic               note_ready;
    logic               note_on;
    logic [NOTE_W-1:0]  note_idx;
    logic [NOTE_W-1:0]  table_idx;
    logic [PHASE_W-1:0] freq_step;
    logic               phase_valid;
    logic [VOICE_W-1:0] phase_voice;
    logic [PHASE_W-1:0] phase_out;
    logic               phase_gate;
    logic               busy;
    logic               overrun;

    // Event source, lookup table and phase consumer side
    modport master (
        output sample_tick, note_valid, note_on, note_idx, freq_step,
        input  note_ready, table_idx, phase_valid, phase_voice, phase_out,
               phase_gate, busy, overrun
    );

    // Scheduler side
    modport slave (
        input  sample_tick, note_valid, note_on, note_idx, freq_step,
        output note_ready, table_idx, phase_valid, phase_voice, phase_out,
               phase_gate, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/voice_phase_scheduler_voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : voice_alloc
//  Purpose  : Combinational voice allocator. Picks the target voice and the
//             action for a note event: retrigger a gated voice playing the
//             same note, else take the lowest free voice, else steal.
//             Note-off targets the lowest gated voice with a matching note.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 3
) (
    input  logic [NUM_VOICES-1:0]             gates,
    input  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes,
    input  logic                              ev_on,
    input  logic [NOTE_W-1:0]                 ev_idx,
    input  logic [VOICE_W-1:0]                steal_ptr,
    output logic [VOICE_W-1:0]                target,
    output alloc_act_t                        action
);

    logic               match_found;
    logic [VOICE_W-1:0] match_v;
    logic               free_found;
    logic [VOICE_W-1:0] free_v;

    // Lowest-index search: scanning downwards lets the lowest hit win
    always_comb begin
        match_found = 1'b0;
        match_v     = '0;
        free_found  = 1'b0;
        free_v      = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gates[i] && (notes[i] == ev_idx)) begin
                match_found = 1'b1;
                match_v     = VOICE_W'(i);
            end
            if (!gates[i]) begin
                free_found = 1'b1;
                free_v     = VOICE_W'(i);
            end
        end
    end

    // Priority resolution of the event into a target voice and an action
    always_comb begin
        target = '0;
        action = ACT_NONE;
        if (ev_on) begin
            if (match_found) begin
                target = match_v;
                action = ACT_RETRIG;
            end else if (free_found) begin
                target = free_v;
                action = ACT_FREE;
            end else begin
                target = steal_ptr;
                action = ACT_STEAL;
            end
        end else if (match_found) begin
            target = match_v;
            action = ACT_OFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : voice_phase_scheduler
//  Purpose  : Time-multiplexes one external note-to-step table across all
//             voices. Each sample tick sweeps every voice (LOOKUP, ACCUM),
//             advances its phase accumulator and emits one phase word.
//             Note events are accepted only between sweeps.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_phase_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    voice_phase_scheduler_if.slave  bus
);

    state_t                            state;
    logic [VOICE_W-1:0]                v;
    logic [VOICE_W-1:0]                steal_ptr;
    voice_t                            voices [NUM_VOICES];

    logic [NUM_VOICES-1:0]             gate_vec;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] note_vec;
    logic [VOICE_W-1:0]                alloc_target;
    alloc_act_t                        alloc_action;
    logic                              accept;
    logic [NOTE_W-1:0]                 note0_next;
    logic [PHASE_W-1:0]                phase_sum;
    logic                              last_voice;

    // Flatten the voice records into the vectors the allocator scans
    always_comb begin
        gate_vec = '0;
        note_vec = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gate_vec[i] = voices[i].gate;
            note_vec[i] = voices[i].note;
        end
    end

    voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .VOICE_W    (VOICE_W)
    ) u_voice_alloc (
        .gates     (gate_vec),
        .notes     (note_vec),
        .ev_on     (bus.note_on),
        .ev_idx    (bus.note_idx),
        .steal_ptr (steal_ptr),
        .target    (alloc_target),
        .action    (alloc_action)
    );

    // Event acceptance, sweep bookkeeping and the accumulator adder
    always_comb begin
        accept     = (state == IDLE) && bus.note_valid;
        // A tick coinciding with an event must present the post-event note of
        // voice 0, since table_idx is loaded on the same edge
        note0_next = voices[0].note;
        if (accept && (alloc_target == '0) &&
            ((alloc_action == ACT_FREE) || (alloc_action == ACT_STEAL))) begin
            note0_next = bus.note_idx;
        end
        phase_sum  = voices[v].phase + bus.freq_step;
        last_voice = (v == VOICE_W'(NUM_VOICES - 1));
    end

    // Sweep FSM with registered outputs and per-voice state updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            v               <= '0;
            steal_ptr       <= '0;
            bus.note_ready  <= 1'b1;
            bus.table_idx   <= '0;
            bus.phase_valid <= 1'b0;
            bus.phase_voice <= '0;
            bus.phase_out   <= '0;
            bus.phase_gate  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.overrun     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '0;
            end
        end else begin
            // A tick during a sweep is dropped and flagged one cycle later
            bus.overrun <= bus.sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    bus.phase_valid <= 1'b0;
                    if (accept) begin
                        case (alloc_action)
                            ACT_RETRIG: voices[alloc_target].phase <= '0;
                            ACT_FREE, ACT_STEAL: begin
                                voices[alloc_target].note  <= bus.note_idx;
                                voices[alloc_target].phase <= '0;
                                voices[alloc_target].gate  <= 1'b1;
                            end
                            ACT_OFF:    voices[alloc_target].gate <= 1'b0;
                            default: ;
                        endcase
                        if (alloc_action == ACT_STEAL) begin
                            steal_ptr <= steal_ptr + VOICE_W'(1);
                        end
                    end
                    if (bus.sample_tick) begin
                        state          <= LOOKUP;
                        v              <= '0;
                        bus.busy       <= 1'b1;
                        bus.note_ready <= 1'b0;
                        bus.table_idx  <= note0_next;
                    end
                end
                LOOKUP: begin
                    // The table result is folded straight into the registered
                    // phase word so ACCUM presents it without a second adder
                    voices[v].phase <= phase_sum;
                    bus.phase_out   <= phase_sum;
                    bus.phase_voice <= v;
                    bus.phase_gate  <= voices[v].gate;
                    bus.phase_valid <= 1'b1;
                    state           <= ACCUM;
                end
                ACCUM: begin
                    bus.phase_valid <= 1'b0;
                    if (last_voice) begin
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                        bus.note_ready <= 1'b1;
                    end else begin
                        v             <= v + VOICE_W'(1);
                        bus.table_idx <= voices[v + VOICE_W'(1)].note;
                        state         <= LOOKUP;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.busy       <= 1'b0;
                    bus.note_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
